// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer slice: ALU opcode constants,
// the controller state encoding and the instruction field layout.
// No ports; imported by alu_regfile and alu_sequencer.
package alu_sequencer_pkg;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Instruction word layout. The immediate overlays the two read
  // address fields when the LI flag is set.
  localparam int INSTR_W = 10;
  localparam int LI_BIT  = 9;
  localparam int OP_LSB  = 6;
  localparam int WA_LSB  = 4;
  localparam int RAS_LSB = 2;
  localparam int RAT_LSB = 0;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic       li;
    logic [2:0] op;
    logic [1:0] wa;
    logic [1:0] ra_s;
    logic [1:0] ra_t;
    logic [3:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.li   = raw[LI_BIT];
    d.op   = raw[OP_LSB +: 3];
    d.wa   = raw[WA_LSB +: 2];
    d.ra_s = raw[RAS_LSB +: 2];
    d.ra_t = raw[RAT_LSB +: 2];
    d.imm  = raw[IMM_LSB +: 4];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
// 4-entry x 4-bit register file with two asynchronous read ports and one
// synchronous write port. Synchronous active-high reset loads REG_RST
// into every entry and takes priority over a write in the same cycle.
// Ports:
//   clk, rst          clock and synchronous reset
//   we, waddr, wdata  write port
//   raddr_s, rdata_s  read port feeding the ALU rs operand
//   raddr_t, rdata_t  read port feeding the ALU rt operand
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter logic [3:0] REG_RST = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr_s,
  output logic [3:0] rdata_s,
  input  logic [1:0] raddr_t,
  output logic [3:0] rdata_t
);

  logic [3:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= REG_RST;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_s = regs[raddr_s];
  assign rdata_t = regs[raddr_t];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Accepts one instruction at a time, reads operands from a 4x4 register
// file, drives an external combinational ALU, writes the result back and
// offers it on a valid/ready output. LI instructions bypass the ALU.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready, in_instr  instruction handshake
//   alu_sel, alu_rs, alu_rt       registered drive to the external ALU
//   alu_rd                        combinational ALU result
//   out_valid, out_ready          result handshake
//   out_data, out_waddr           written value and destination register
//   retired                       completed output handshakes (wraps)
//   busy                          high whenever not idle
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int         CNT_W   = 8,
  parameter logic [3:0] REG_RST = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9:0]         in_instr,
  output logic [2:0]         alu_sel,
  output logic [3:0]         alu_rs,
  output logic [3:0]         alu_rt,
  input  logic [3:0]         alu_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_data,
  output logic [1:0]         out_waddr,
  output logic [CNT_W-1:0]   retired,
  output logic               busy
);

  state_t     state;
  state_t     next_state;
  instr_t     dec;
  logic [1:0] wa_q;
  logic       accept;

  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [3:0] rf_wdata;
  logic [3:0] rd_s;
  logic [3:0] rd_t;

  assign dec      = decode_instr(in_instr);
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;

  alu_regfile #(
    .REG_RST (REG_RST)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_s (dec.ra_s),
    .rdata_s (rd_s),
    .raddr_t (dec.ra_t),
    .rdata_t (rd_t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the single register-file write per instruction: the
  // immediate on the accept edge for LI, or the ALU result on the EXEC edge.
  // The WB state never writes, so backpressure cannot cause a re-write.
  always_comb begin
    next_state = state;
    rf_we      = 1'b0;
    rf_waddr   = dec.wa;
    rf_wdata   = dec.imm;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = dec.li ? ST_WB : ST_EXEC;
          rf_we      = dec.li;
        end
      end
      ST_EXEC: begin
        next_state = ST_WB;
        rf_we      = 1'b1;
        rf_waddr   = wa_q;
        rf_wdata   = alu_rd;
      end
      ST_WB: begin
        if (out_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath registers. Operands are captured at accept, so an instruction
  // whose destination equals a source still computes from the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel   <= 3'd0;
      alu_rs    <= 4'd0;
      alu_rt    <= 4'd0;
      wa_q      <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_waddr <= 2'd0;
      retired   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wa_q <= dec.wa;
            if (dec.li) begin
              out_data  <= dec.imm;
              out_waddr <= dec.wa;
              out_valid <= 1'b1;
            end else begin
              alu_sel <= dec.op;
              alu_rs  <= rd_s;
              alu_rt  <= rd_t;
            end
          end
        end
        ST_EXEC: begin
          out_data  <= alu_rd;
          out_waddr <= wa_q;
          out_valid <= 1'b1;
        end
        ST_WB: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            retired   <= retired + 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
